// File: rtl/eth_tx_frame_feeder.sv
// eth_tx_frame_feeder: buffers one 16-bit-word frame, then streams it (zero-padded to MIN_WORDS)
// through the Ethernet send handshake with a tx-complete timeout.
module eth_tx_frame_feeder #(
   parameter int DEPTH_LOG2     = 10,
   parameter int MIN_WORDS      = 30,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  wr_en_in,
   input  logic [15:0]           wr_data_in,
   input  logic                  commit_in,
   output logic                  wr_full_out,
   output logic                  busy_out,
   output logic                  done_out,
   output logic                  error_out,
   output logic                  overflow_out,
   output logic [DEPTH_LOG2:0]   word_count_out,
   output logic [15:0]           ethernet_data_out,
   output logic                  ethernet_send_req_out,
   input  logic                  ethernet_data_rdy_in,
   input  logic                  ethernet_tx_complete_in
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DEPTH_LOG2:0] FULL  = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0] MIN_L = MIN_WORDS[DEPTH_LOG2:0];
   localparam logic [TW-1:0]       TMO   = TIMEOUT_CYCLES[TW-1:0];
   typedef enum logic [1:0] {FILL, STREAM, WAIT_CMPL, DONE} state_t;
   state_t              r_state;
   logic [15:0]         r_mem [0:2**DEPTH_LOG2-1];
   logic [DEPTH_LOG2:0] r_count, r_rd_ptr;
   logic [TW-1:0]       r_tmo;
   logic                r_busy, r_done, r_error, r_ovf, r_send_req;
   logic                w_full, w_wr_ok, w_wr_drop, w_commit, w_active;
   logic [DEPTH_LOG2:0] w_len;
   assign w_full    = r_count == FULL;
   assign w_wr_ok   = r_state == FILL && wr_en_in && !w_full;
   assign w_wr_drop = wr_en_in && (r_state != FILL || w_full);
   // a write in the commit cycle counts toward a non-empty frame
   assign w_commit  = r_state == FILL && commit_in && (r_count != '0 || w_wr_ok);
   assign w_len     = r_count > MIN_L ? r_count : MIN_L;
   assign w_active  = r_state == STREAM || r_state == WAIT_CMPL;
   assign wr_full_out           = w_full;
   assign busy_out              = r_busy;
   assign done_out              = r_done;
   assign error_out             = r_error;
   assign overflow_out          = r_ovf;
   assign word_count_out        = r_count;
   assign ethernet_send_req_out = r_send_req;
   assign ethernet_data_out     = (r_state == STREAM && r_rd_ptr < r_count) ? r_mem[r_rd_ptr[DEPTH_LOG2-1:0]] : '0;
   always_ff @(posedge Clock)
      if (w_wr_ok) r_mem[r_count[DEPTH_LOG2-1:0]] <= wr_data_in;
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= FILL;
         r_count    <= '0;
         r_rd_ptr   <= '0;
         r_tmo      <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_ovf      <= 1'b0;
         r_send_req <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_error <= 1'b0;
         r_ovf   <= w_wr_drop ? 1'b1 : w_commit ? 1'b0 : r_ovf;
         r_tmo   <= w_active ? r_tmo + 1'b1 : '0;
         case (r_state)
            FILL: begin
               if (w_wr_ok) r_count <= r_count + 1'b1;
               if (w_commit) begin
                  r_state    <= STREAM;
                  r_busy     <= 1'b1;
                  r_send_req <= 1'b1;
                  r_rd_ptr   <= '0;
               end
            end
            STREAM, WAIT_CMPL: begin
               if (ethernet_tx_complete_in) begin
                  r_state    <= DONE;
                  r_send_req <= 1'b0;
                  r_busy     <= 1'b0;
                  r_done     <= 1'b1;
               end else if (r_tmo == TMO) begin
                  r_state    <= FILL;
                  r_send_req <= 1'b0;
                  r_busy     <= 1'b0;
                  r_error    <= 1'b1;
                  r_count    <= '0;
                  r_rd_ptr   <= '0;
               end else if (r_state == STREAM && ethernet_data_rdy_in) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
                  if (r_rd_ptr + 1'b1 == w_len) r_state <= WAIT_CMPL;
               end
            end
            default: begin
               r_state  <= FILL;
               r_count  <= '0;
               r_rd_ptr <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_eth_tx_frame_feeder.sv
// tb_eth_tx_frame_feeder: randomized frames checked against a queue-based frame model.
module tb_eth_tx_frame_feeder;
   localparam int DL = 10, MW = 30, TO = 100, DEPTH = 1024;
   logic        Clock = 1'b0, Reset = 1'b1;
   logic        wr_en_in = 1'b0, commit_in = 1'b0;
   logic [15:0] wr_data_in = '0;
   logic        ethernet_data_rdy_in = 1'b0, ethernet_tx_complete_in = 1'b0;
   logic        wr_full_out, busy_out, done_out, error_out, overflow_out, ethernet_send_req_out;
   logic [DL:0] word_count_out;
   logic [15:0] ethernet_data_out;
   int          n_cmp = 0, n_bad = 0;
   logic [15:0] q[$];
   bit          m_ovf = 1'b0;

   eth_tx_frame_feeder #(.DEPTH_LOG2(DL), .MIN_WORDS(MW), .TIMEOUT_CYCLES(TO)) dut (
      .Clock(Clock), .Reset(Reset), .wr_en_in(wr_en_in), .wr_data_in(wr_data_in),
      .commit_in(commit_in), .wr_full_out(wr_full_out), .busy_out(busy_out),
      .done_out(done_out), .error_out(error_out), .overflow_out(overflow_out),
      .word_count_out(word_count_out), .ethernet_data_out(ethernet_data_out),
      .ethernet_send_req_out(ethernet_send_req_out), .ethernet_data_rdy_in(ethernet_data_rdy_in),
      .ethernet_tx_complete_in(ethernet_tx_complete_in));

   always #5 Clock = ~Clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(negedge Clock);
   endtask

   task automatic write_words(int n, bit rnd, logic [15:0] base);
      for (int i = 0; i < n; i++) begin
         wr_en_in   = 1'b1;
         wr_data_in = rnd ? 16'($urandom) : base + 16'(i);
         tick;
         if (q.size() < DEPTH) q.push_back(wr_data_in);
         else m_ovf = 1'b1;
      end
      wr_en_in = 1'b0;
      check("wcount", word_count_out, q.size());
      check("wovf", overflow_out, m_ovf);
      check("wfull", wr_full_out, q.size() == DEPTH);
   endtask

   task automatic commit_frame(bit with_word, logic [15:0] w);
      commit_in  = 1'b1;
      wr_en_in   = with_word;
      wr_data_in = w;
      tick;
      commit_in = 1'b0;
      wr_en_in  = 1'b0;
      if (with_word) q.push_back(w);
      m_ovf = 1'b0;
      check("creq", ethernet_send_req_out, 1);
      check("cbusy", busy_out, 1);
      check("covf", overflow_out, 0);
      check("ccount", word_count_out, q.size());
   endtask

   // streams the modelled frame with random rdy, then completes it
   task automatic run_frame(int pct, int early, int delay, int cyc0);
      int len, k, cyc;
      logic r;
      len = q.size() > MW ? q.size() : MW;
      k   = 0;
      cyc = cyc0;
      while (k < len && k != early && cyc < TO - 8) begin
         r = $urandom_range(0, 99) < pct;
         ethernet_data_rdy_in = r;
         check("data", ethernet_data_out, k < q.size() ? q[k] : 16'h0);
         check("sreq", ethernet_send_req_out, 1);
         tick;
         k += int'(r);
         cyc++;
      end
      ethernet_data_rdy_in = 1'b0;
      if (k != early) check("slen", k, len);
      for (int i = 0; i < delay; i++) begin
         ethernet_data_rdy_in = 1'b1;
         check("wdata", ethernet_data_out, 0);
         check("wreq", ethernet_send_req_out, 1);
         check("wdone", done_out, 0);
         tick;
      end
      ethernet_data_rdy_in    = 1'b0;
      ethernet_tx_complete_in = 1'b1;
      tick;
      ethernet_tx_complete_in = 1'b0;
      check("done", done_out, 1);
      check("dreq", ethernet_send_req_out, 0);
      check("derr", error_out, 0);
      tick;
      check("done_end", done_out, 0);
      check("dcount", word_count_out, 0);
      check("dbusy", busy_out, 0);
      check("dreq2", ethernet_send_req_out, 0);
      q.delete();
   endtask

   initial begin
      repeat (3) tick;
      Reset = 1'b0;
      check("rst_req", ethernet_send_req_out, 0);
      check("rst_busy", busy_out, 0);
      check("rst_count", word_count_out, 0);
      check("rst_data", ethernet_data_out, 0);
      check("rst_flags", {wr_full_out, done_out, error_out, overflow_out}, 0);

      // 40 counting words, a dropped write during streaming, continuous rdy
      write_words(40, 1'b0, 16'h0001);
      commit_frame(1'b0, 16'h0);
      wr_en_in = 1'b1;
      tick;
      wr_en_in = 1'b0;
      m_ovf = 1'b1;
      check("sovf", overflow_out, m_ovf);
      check("scount", word_count_out, 40);
      run_frame(100, -1, 2, 1);

      // empty commit is ignored
      commit_in = 1'b1;
      tick;
      commit_in = 1'b0;
      check("ereq", ethernet_send_req_out, 0);
      check("ebusy", busy_out, 0);
      tick;
      check("ereq2", ethernet_send_req_out, 0);

      // timeout with rdy toggling and no tx-complete
      write_words(3, 1'b1, 16'h0);
      commit_frame(1'b0, 16'h0);
      for (int c = 0; c <= TO; c++) begin
         ethernet_data_rdy_in = (c % 2) == 0;
         check("terr", error_out, 0);
         check("treq", ethernet_send_req_out, 1);
         tick;
      end
      ethernet_data_rdy_in = 1'b0;
      check("terr1", error_out, 1);
      check("treq0", ethernet_send_req_out, 0);
      check("tdone", done_out, 0);
      check("tbusy", busy_out, 0);
      tick;
      check("terr0", error_out, 0);
      check("tcount", word_count_out, 0);
      q.delete();

      // short frame padded to MIN_WORDS after a timeout
      write_words(5, 1'b0, 16'hA000);
      commit_frame(1'b0, 16'h0);
      run_frame(100, -1, 3, 0);

      // tx-complete on the timeout terminal cycle is a success
      write_words(2, 1'b1, 16'h0);
      commit_frame(1'b0, 16'h0);
      ethernet_data_rdy_in = 1'b1;
      repeat (TO) tick;
      ethernet_data_rdy_in    = 1'b0;
      ethernet_tx_complete_in = 1'b1;
      tick;
      ethernet_tx_complete_in = 1'b0;
      check("kdone", done_out, 1);
      check("kerr", error_out, 0);
      tick;
      check("kerr2", error_out, 0);
      check("kcount", word_count_out, 0);
      q.delete();

      // early completion mid-stream
      write_words(20, 1'b1, 16'h0);
      commit_frame(1'b0, 16'h0);
      run_frame(100, 10, 0, 0);

      // fill to capacity, overflow, then reset mid-stream
      write_words(DEPTH, 1'b1, 16'h0);
      write_words(1, 1'b1, 16'h0);
      commit_frame(1'b0, 16'h0);
      for (int k = 0; k < 20; k++) begin
         ethernet_data_rdy_in = 1'b1;
         check("fdata", ethernet_data_out, q[k]);
         tick;
      end
      ethernet_data_rdy_in = 1'b0;
      Reset = 1'b1;
      tick;
      Reset = 1'b0;
      q.delete();
      m_ovf = 1'b0;
      check("xreq", ethernet_send_req_out, 0);
      check("xbusy", busy_out, 0);
      check("xcount", word_count_out, 0);
      check("xdata", ethernet_data_out, 0);
      check("xflags", {wr_full_out, done_out, error_out, overflow_out}, 0);

      // write and commit in the same cycle after 31 words
      write_words(31, 1'b1, 16'h0);
      commit_frame(1'b1, 16'($urandom));
      check("mcount", word_count_out, 32);
      run_frame(90, -1, 1, 0);

      for (int f = 0; f < 5; f++) begin
         write_words($urandom_range(1, 50), 1'b1, 16'h0);
         commit_frame(1'b0, 16'h0);
         run_frame(80, -1, $urandom_range(0, 3), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
